// File: rtl/psum_drain.sv
// psum_drain: removes the diagonal skew from the systolic array's bottom-row
// partial sums and queues aligned rows in a small FIFO for the writeback stage.
//   clk, reset_n   : clock, synchronous active-low reset
//   en             : array enable; low flushes partially aligned vectors
//   sum_i          : bottom-row outputs, column c at [c*PSUM_W +: PSUM_W]
//   sum_valid_i    : column 0 of sum_i carries a valid result this cycle
//   out_data       : head row of the FIFO (0 when empty)
//   out_valid      : FIFO non-empty
//   out_ready      : consumer accepts the head row
//   full           : FIFO holds DEPTH rows
//   overflow       : sticky flag, a row was dropped while full
//   count          : rows currently stored
module psum_drain #(
    parameter int unsigned N      = 4,
    parameter int unsigned PSUM_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en,
    input  logic [N*PSUM_W-1:0]          sum_i,
    input  logic                         sum_valid_i,
    output logic [N*PSUM_W-1:0]          out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         full,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned ROW_W = N * PSUM_W;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ROW_W-1:0] row_c;
    logic [N-2:0]     vpipe;
    logic             push_c;
    logic             pop_c;
    logic             push_ok_c;

    // Column c is delayed N-1-c cycles so every column lines up with column N-1.
    for (genvar c = 0; c < N - 1; c++) begin : g_skew
        localparam int unsigned STAGES = N - 1 - c;
        logic [PSUM_W-1:0] pipe [STAGES];

        always_ff @(posedge clk) begin
            if (!reset_n || !en) begin
                for (int s = 0; s < int'(STAGES); s++) pipe[s] <= '0;
            end else begin
                pipe[0] <= sum_i[c*PSUM_W +: PSUM_W];
                for (int s = 1; s < int'(STAGES); s++) pipe[s] <= pipe[s-1];
            end
        end

        assign row_c[c*PSUM_W +: PSUM_W] = pipe[STAGES-1];
    end

    // Last column needs no delay.
    assign row_c[(N-1)*PSUM_W +: PSUM_W] = sum_i[(N-1)*PSUM_W +: PSUM_W];

    // Valid travels alongside column 0.
    always_ff @(posedge clk) begin
        if (!reset_n || !en) begin
            vpipe <= '0;
        end else begin
            vpipe[0] <= sum_valid_i;
            for (int s = 1; s < int'(N - 1); s++) vpipe[s] <= vpipe[s-1];
        end
    end

    // A row aligned in a cycle where en is low is discarded too.
    assign push_c    = vpipe[N-2] && en;
    assign pop_c     = out_valid && out_ready;
    assign push_ok_c = push_c && (!full || pop_c);

    logic [ROW_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_nxt;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ROW_W-1:0] head_nxt;

    // Storage array, written only by accepted pushes.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= row_c;
    end

    // Next FIFO state; the head register is loaded with whatever slot rd_nxt
    // will point at, taking the incoming row when that slot is written now.
    always_comb begin
        rd_nxt   = rd_ptr;
        wr_nxt   = wr_ptr;
        cnt_nxt  = count;
        head_nxt = '0;
        if (pop_c)     rd_nxt = rd_ptr + PTR_W'(1);
        if (push_ok_c) wr_nxt = wr_ptr + PTR_W'(1);
        if (push_ok_c && !pop_c)      cnt_nxt = count + CNT_W'(1);
        else if (!push_ok_c && pop_c) cnt_nxt = count - CNT_W'(1);
        if (cnt_nxt != '0) begin
            if (push_ok_c && (wr_ptr == rd_nxt)) head_nxt = row_c;
            else                                 head_nxt = mem[rd_nxt];
        end
    end

    // FIFO state and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            count     <= cnt_nxt;
            out_valid <= (cnt_nxt != '0);
            full      <= (cnt_nxt == CNT_W'(DEPTH));
            overflow  <= overflow | (push_c && full && !pop_c);
            out_data  <= head_nxt;
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed scenarios plus randomized traffic for psum_drain,
// checked each cycle against a queue-based model of aligned rows.
module tb_psum_drain;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = N * W;
    localparam int          MAXC  = 560;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            en;
    logic [RW-1:0]   sum_i;
    logic            sum_valid_i;
    logic [RW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            full;
    logic            overflow;
    logic [2:0]      count;

    always #5 clk = ~clk;

    psum_drain #(.N(N), .PSUM_W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .sum_i      (sum_i),
        .sum_valid_i(sum_valid_i),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .full       (full),
        .overflow   (overflow),
        .count      (count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle stimulus schedule.
    bit          lv    [MAXC];
    bit          en_h  [MAXC];
    bit          rst_h [MAXC];
    bit          rdy_h [MAXC];
    logic [W-1:0] ld   [MAXC][N];

    task automatic launch(input int t, input logic [W-1:0] base);
        lv[t] = 1'b1;
        for (int c = 0; c < int'(N); c++) ld[t][c] = base + W'(c);
    endtask

    // A vector launched at t-(N-1) reaches the FIFO at t only if the array
    // stayed enabled and out of reset for its whole journey.
    function automatic bit survives(input int t);
        for (int k = t - int'(N) + 1; k <= t; k++)
            if (!en_h[k] || rst_h[k]) return 1'b0;
        return lv[t - int'(N) + 1];
    endfunction

    function automatic logic [RW-1:0] row_of(input int t);
        logic [RW-1:0] r;
        for (int c = 0; c < int'(N); c++) r[c*W +: W] = ld[t][c];
        return r;
    endfunction

    logic [RW-1:0] q[$];
    bit            m_ovf;

    initial begin
        for (int t = 0; t < MAXC; t++) begin
            lv[t] = 0; en_h[t] = 1; rst_h[t] = 0; rdy_h[t] = 1;
            for (int c = 0; c < int'(N); c++) ld[t][c] = '0;
        end
        rst_h[0] = 1; rst_h[1] = 1;

        // single vector
        launch(10, 16'h0100);
        // streaming
        for (int k = 0; k < 6; k++) launch(30 + k, W'(16 * k));
        // backpressure with overflow
        for (int t = 50; t < 65; t++) rdy_h[t] = 0;
        for (int k = 0; k < 5; k++) launch(50 + k, W'(16'h0200 + 16 * k));
        rst_h[80] = 1;
        // full with simultaneous pop
        for (int t = 85; t < 110; t++) rdy_h[t] = 0;
        rdy_h[100] = 1;
        for (int k = 0; k < 4; k++) launch(90 + k, W'(16'h0300 + 16 * k));
        launch(97, 16'h0340);
        // en drop
        for (int t = 118; t < 145; t++) rdy_h[t] = 0;
        launch(120, 16'h0400);
        launch(121, 16'h0410);
        launch(129, 16'h0440);
        launch(130, 16'h0420);
        launch(132, 16'h0450);
        en_h[132] = 0;
        launch(136, 16'h0430);
        // reset mid-stream
        for (int t = 155; t < 176; t++) rdy_h[t] = 0;
        for (int k = 0; k < 3; k++) launch(160 + k, W'(16'h0500 + 16 * k));
        launch(165, 16'h0530);
        launch(166, 16'h0540);
        rst_h[167] = 1;
        launch(168, 16'h0550);
        // randomized traffic
        for (int t = 200; t < MAXC - 10; t++) begin
            if ($urandom_range(0, 1) == 1) launch(t, W'($urandom));
            en_h[t]  = ($urandom_range(0, 15) != 0);
            rdy_h[t] = ($urandom_range(0, 2) != 0);
            rst_h[t] = ($urandom_range(0, 99) == 0);
        end

        reset_n = 0; en = 1; sum_i = '0; sum_valid_i = 0; out_ready = 0;
        q.delete();
        m_ovf = 0;
        @(posedge clk); #1;

        for (int cyc = 0; cyc < MAXC; cyc++) begin
            bit pop;
            bit push;
            reset_n     = !rst_h[cyc];
            en          = en_h[cyc];
            sum_valid_i = lv[cyc];
            out_ready   = rdy_h[cyc];
            for (int c = 0; c < int'(N); c++) begin
                if (cyc >= c && lv[cyc-c]) sum_i[c*W +: W] = ld[cyc-c][c];
                else                       sum_i[c*W +: W] = W'($urandom);
            end

            @(negedge clk);
            if (cyc > 0) begin
                check($sformatf("out_valid@%0d", cyc), 64'(out_valid), 64'(q.size() != 0));
                check($sformatf("count@%0d", cyc), 64'(count), 64'(q.size()));
                check($sformatf("full@%0d", cyc), 64'(full), 64'(q.size() == DEPTH));
                check($sformatf("overflow@%0d", cyc), 64'(overflow), 64'(m_ovf));
                check($sformatf("out_data@%0d", cyc), out_data,
                      (q.size() != 0) ? q[0] : 64'h0);
            end
            if (cyc == 14) check("single_row", out_data, 64'h0103_0102_0101_0100);
            if (cyc == 57) check("bp_full", 64'(full), 64'h1);
            if (cyc == 58) check("bp_overflow", 64'(overflow), 64'h1);

            if (rst_h[cyc]) begin
                q.delete();
                m_ovf = 0;
            end else begin
                pop  = (q.size() != 0) && rdy_h[cyc];
                push = (cyc >= int'(N) - 1) && survives(cyc);
                if (pop) void'(q.pop_front());
                if (push) begin
                    if (q.size() < DEPTH) q.push_back(row_of(cyc - int'(N) + 1));
                    else                  m_ovf = 1;
                end
            end

            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
